alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have, for N in {0,1}: reqN_valid in 1 (request present); reqN_sel in 2 (00 add, 01 nand, others add); reqN_a in 16; reqN_b in 16; reqN_ready out 1 (request accepted this cycle).
REQ-004 SHALL have ALU-side ports: alu_sel out 2; alu_arg1 out 16; alu_arg2 out 16; alu_result in 16; alu_carry in 1; alu_zero in 1.
REQ-005 SHALL have response ports: rsp_valid out 1; rsp_id out 1 (requester index); rsp_result out 16; rsp_carry out 1; rsp_zero out 1; rsp_ready in 1 (consumer accepts).

Function
REQ-006 SHALL share one combinational 16-bit add/nand ALU between two requesters, one operation accepted per cycle max.
REQ-007 SHALL hold a single-entry response buffer with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-008 SHALL define can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
REQ-009 SHALL assert at most one reqN_ready, only when can_accept and reqN_valid; reqN_ready is combinational.
REQ-010 SHALL arbitrate round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-011 SHALL update last-granted pointer only on an accepted transfer.
REQ-012 SHALL drive alu_sel/alu_arg1/alu_arg2 from the granted requester's sel/a/b in the accept cycle; otherwise drive 2'b00/16'h0000/16'h0000.
REQ-013 SHALL, on the edge ending an accept cycle, load rsp_result/rsp_carry/rsp_zero from alu_result/alu_carry/alu_zero unmodified, load rsp_id with granted index, go FULL; latency 1 cycle request-accept to rsp_valid.
REQ-014 SHALL, when FULL and rsp_ready=1 with no new accept, go EMPTY next edge.
REQ-015 SHALL, when FULL, rsp_ready=1 and a new accept occur in the same cycle, stay FULL and load the new response (back-to-back, one result per cycle).
REQ-016 SHALL hold all rsp_* outputs stable while FULL and rsp_ready=0; both reqN_ready SHALL be 0 then.
REQ-017 SHALL ignore reqN_sel/a/b when not granted; rsp_result etc. hold last value when EMPTY.
REQ-018 SHALL maintain a 16-bit op counter incrementing on every accept, wrapping 16'hFFFF to 16'h0000 (internal, visible for debug only).

Reset
REQ-019 SHALL, on rst=1 at a rising edge, set state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=16'h0000, rsp_carry=0, rsp_zero=0, last-granted=1 (requester 0 wins first tie), op counter=0.
REQ-020 SHALL force reqN_ready=0 while rst=1; a response pending at reset SHALL be discarded.

Configuration
REQ-021 SHALL honour macro ALU_ARBITER_FIXED_PRIO_EN: defined -> fixed priority, requester 0 always wins ties, pointer unused; undefined -> round-robin per REQ-010.

Verification
REQ-022 SHALL cover: req0 add a=16'hFFFF b=16'h0001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=16'h0000, rsp_carry=1, rsp_zero=1.
REQ-023 SHALL cover: req1 nand a=16'hF0F0 b=16'hFF00 -> rsp_id=1, rsp_result=16'h0FFF, rsp_carry=1 (ALU add carry passed through), rsp_zero=0.
REQ-024 SHALL cover: both valid every cycle, rsp_ready=1, round-robin build -> grants 0,1,0,1 on consecutive cycles, one rsp per cycle; fixed-prio build -> grants 0,0,0,0.
REQ-025 SHALL cover: FULL then rsp_ready=0 for 3 cycles with both requests valid -> reqN_ready=0, rsp_* unchanged; rsp_ready=1 -> same-cycle new grant, buffer reloads next edge.
REQ-026 SHALL cover: rst=1 while FULL with req0_valid=1 -> next cycle rsp_valid=0, all rsp_* zero, no ready during reset; first tie after reset granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational add/nand ALU,
// with a single-entry response buffer. Define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins).

module alu_arbiter_lane (
    input  logic        valid,
    input  logic        granted,
    input  logic        accept,
    input  logic [1:0]  sel,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic [1:0]  sel_m,
    output logic [15:0] a_m,
    output logic [15:0] b_m
);
    // Masked operands let the top OR-combine lanes into the ALU bus.
    assign ready = accept & valid & granted;
    assign sel_m = ready ? sel : 2'b00;
    assign a_m   = ready ? a   : 16'h0000;
    assign b_m   = ready ? b   : 16'h0000;
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_sel,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_sel,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic [1:0]  alu_sel,
    output logic [15:0] alu_arg1,
    output logic [15:0] alu_arg2,
    input  logic [15:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    input  logic        rsp_ready
);
    localparam int NUM_LANES = 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_next;

    logic [NUM_LANES-1:0]       req_valid;
    logic [NUM_LANES-1:0][1:0]  req_sel, sel_m;
    logic [NUM_LANES-1:0][15:0] req_a, req_b, a_m, b_m;
    logic [NUM_LANES-1:0]       ready;
    logic                       gnt_idx;
    logic                       can_accept;
    logic                       accept;
    logic [15:0]                op_cnt;

    assign req_valid = {req1_valid, req0_valid};
    assign req_sel   = {req1_sel, req0_sel};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    assign gnt_idx = ~req_valid[0];
`else
    logic last;

    always_comb begin
        if (&req_valid) gnt_idx = ~last;
        else            gnt_idx = req_valid[1];
    end

    always_ff @(posedge clk) begin
        if (rst)         last <= 1'b1;
        else if (accept) last <= gnt_idx;
    end
`endif

    assign can_accept = (state == EMPTY) | (rsp_valid & rsp_ready);
    assign accept     = can_accept & (|req_valid) & ~rst;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        alu_arbiter_lane u_lane (
            .valid   (req_valid[i]),
            .granted (gnt_idx == 1'(i)),
            .accept  (accept),
            .sel     (req_sel[i]),
            .a       (req_a[i]),
            .b       (req_b[i]),
            .ready   (ready[i]),
            .sel_m   (sel_m[i]),
            .a_m     (a_m[i]),
            .b_m     (b_m[i])
        );
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        alu_sel  = 2'b00;
        alu_arg1 = 16'h0000;
        alu_arg2 = 16'h0000;
        for (int i = 0; i < NUM_LANES; i++) begin
            alu_sel  = alu_sel  | sel_m[i];
            alu_arg1 = alu_arg1 | a_m[i];
            alu_arg2 = alu_arg2 | b_m[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (!accept && rsp_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (state == FULL);
    end

    // Response fields hold their last value when the buffer drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id     <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else if (accept) begin
            rsp_id     <= gnt_idx;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         op_cnt <= 16'h0000;
        else if (accept) op_cnt <= op_cnt + 16'h0001;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push hand-computed responses,
// a negedge monitor pops and compares on every rsp handshake.

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_sel, req1_sel;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [1:0]  alu_sel;
    logic [15:0] alu_arg1, alu_arg2, alu_result;
    logic        alu_carry, alu_zero;
    logic        rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_ready;
    logic [15:0] rsp_result;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic        c;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_sel(alu_sel), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ready(rsp_ready)
    );

    // Shared ALU: carry always comes from the adder, whatever the op.
    logic [16:0] sum;
    always_comb begin
        sum        = {1'b0, alu_arg1} + {1'b0, alu_arg2};
        alu_result = (alu_sel == 2'b01) ? ~(alu_arg1 & alu_arg2) : sum[15:0];
        alu_carry  = sum[16];
        alu_zero   = (alu_result == 16'h0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drv(input int n, input logic v, input logic [1:0] s, input logic [15:0] a, input logic [15:0] b);
        if (n == 0) begin req0_valid = v; req0_sel = s; req0_a = a; req0_b = b; end
        else        begin req1_valid = v; req1_sel = s; req1_a = a; req1_b = b; end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t e;
            exp_t g;
            g = {rsp_id, rsp_result, rsp_carry, rsp_zero};
            if (q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL rsp_unexpected: got %h want none", g);
            end else begin
                e = q.pop_front();
                chk("rsp", 32'(g), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    localparam bit RR = 1'b0;
`else
    localparam bit RR = 1'b1;
`endif

    initial begin
        exp_t e5 [2];
        int   g;
        e5[0] = {1'b0, 16'h0000, 1'b1, 1'b1};   // nand FFFF,FFFF; add carry 1
        e5[1] = {1'b1, 16'h0003, 1'b0, 1'b0};   // add 1+2

        rst = 1'b1; rsp_ready = 1'b0;
        drv(0, 1'b1, 2'b00, 16'h0001, 16'h0001);
        drv(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        step(); step();
        @(negedge clk);
        chk("rst_valid",  32'(rsp_valid),  32'h0);
        chk("rst_id",     32'(rsp_id),     32'h0);
        chk("rst_result", 32'(rsp_result), 32'h0);
        chk("rst_cz",     32'({rsp_carry, rsp_zero}), 32'h0);
        chk("rst_ready0", 32'(req0_ready), 32'h0);

        // add FFFF+0001: wraps to zero with carry
        step();
        rst = 1'b0; rsp_ready = 1'b1;
        drv(0, 1'b1, 2'b00, 16'hFFFF, 16'h0001);
        q.push_back({1'b0, 16'h0000, 1'b1, 1'b1});
        @(negedge clk);
        chk("add_rdy", 32'({req1_ready, req0_ready}), 32'h1);
        chk("add_alu", {alu_sel, alu_arg1[13:0], alu_arg2}, {2'b00, 14'h3FFF, 16'h0001});
        step();
        drv(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("add_lat", 32'(rsp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("idle_alu", {14'h0, alu_sel, alu_arg1}, 32'h0);

        // nand F0F0,FF00 from requester 1
        step();
        drv(1, 1'b1, 2'b01, 16'hF0F0, 16'hFF00);
        q.push_back({1'b1, 16'h0FFF, 1'b1, 1'b0});
        @(negedge clk);
        chk("nand_rdy", 32'({req1_ready, req0_ready}), 32'h2);
        step();
        drv(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        step();

        // contention: both valid every cycle
        drv(0, 1'b1, 2'b00, 16'h1234, 16'h1111);
        drv(1, 1'b1, 2'b00, 16'h8000, 16'h8000);
        for (int k = 0; k < 4; k++) begin
            g = RR ? (k % 2) : 0;
            if (g == 0) q.push_back({1'b0, 16'h2345, 1'b0, 1'b0});
            else        q.push_back({1'b1, 16'h0000, 1'b1, 1'b1});
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k), 32'({req1_ready, req0_ready}), (g == 0) ? 32'h1 : 32'h2);
            step();
        end
        drv(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drv(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        step();

        // stall: FULL with rsp_ready low holds everything
        rsp_ready = 1'b0;
        drv(0, 1'b1, 2'b00, 16'h00FF, 16'h0001);
        q.push_back({1'b0, 16'h0100, 1'b0, 1'b0});
        step();
        drv(0, 1'b1, 2'b01, 16'hFFFF, 16'hFFFF);
        drv(1, 1'b1, 2'b00, 16'h0001, 16'h0002);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_rdy%0d", k), 32'({req1_ready, req0_ready}), 32'h0);
            chk($sformatf("stall_rsp%0d", k), {14'h0, rsp_valid, rsp_id, rsp_result}, {14'h0, 1'b1, 1'b0, 16'h0100});
            step();
        end
        rsp_ready = 1'b1;
        g = RR ? 1 : 0;
        q.push_back(e5[g]);
        @(negedge clk);
        chk("release_rdy", 32'({req1_ready, req0_ready}), (g == 0) ? 32'h1 : 32'h2);
        step();
        if (g == 0) drv(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        else        drv(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        q.push_back(e5[1-g]);
        @(negedge clk);
        chk("release2_rdy", 32'({req1_ready, req0_ready}), (g == 0) ? 32'h2 : 32'h1);
        step();
        drv(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drv(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        step();

        // reset while FULL discards the pending response
        rsp_ready = 1'b0;
        drv(0, 1'b1, 2'b00, 16'h0005, 16'h0003);
        step();
        @(negedge clk);
        chk("pre_rst_rsp", {15'h0, rsp_valid, rsp_result}, {15'h0, 1'b1, 16'h0008});
        step();
        rst = 1'b1;
        drv(1, 1'b1, 2'b00, 16'h0007, 16'h0007);
        @(negedge clk);
        chk("in_rst_rdy", 32'({req1_ready, req0_ready}), 32'h0);
        step();
        @(negedge clk);
        chk("post_rst_rsp", {13'h0, rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_result}, 32'h0);
        step();
        rst = 1'b0; rsp_ready = 1'b1;
        q.push_back({1'b0, 16'h0008, 1'b0, 1'b0});
        @(negedge clk);
        chk("rst_tie_rdy", 32'({req1_ready, req0_ready}), 32'h1);
        step();
        drv(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drv(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        step(); step(); step();
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
